// File: rtl/wb_vmon_capture_pkg.sv
// Shared types, header field widths and the byte-select decoder for the
// multi-channel Wishbone write monitor.
package wb_vmon_capture_pkg;

  // Stream framer states: no frame, header byte on the wire, data bytes.
  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA
  } state_e;

  // Header byte layout: {chan[CHAN_W-1:0], nbytes-1[LEN_W-1:0]}.
  localparam int CHAN_W    = 4;
  localparam int LEN_W     = 4;
  localparam int MAX_LANES = 16;

  // Decoded byte-select: ok is set only for a single non-empty run of 1s.
  typedef struct packed {
    logic       ok;
    logic [3:0] lsb_lane;
    logic [4:0] nbytes;
  } sel_info_t;

  // The select is zero-extended to 16 lanes so one decoder serves every bus width.
  function automatic sel_info_t sel_contig(input logic [MAX_LANES-1:0] sel);
    sel_info_t r;
    logic      found;
    logic      ended;
    r          = '0;
    r.ok       = 1'b1;
    found      = 1'b0;
    ended      = 1'b0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (sel[i]) begin
        // A set lane after a gap means a second run.
        if (ended) r.ok = 1'b0;
        if (!found) begin
          found      = 1'b1;
          r.lsb_lane = 4'(i);
        end
        r.nbytes = r.nbytes + 5'd1;
      end else if (found) begin
        ended = 1'b1;
      end
    end
    if (!found) r.ok = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/wb_vmon_capture_if.sv
// Snooped Wishbone bus signals. The bus side drives them (master); the
// passive monitor only observes them (slave).
interface wb_vmon_capture_if #(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32
);
  logic [WB_ADDR_WIDTH-1:0]   ADR;
  logic [WB_DATA_WIDTH-1:0]   DAT_W;
  logic [WB_DATA_WIDTH/8-1:0] SEL;
  logic                       CYC;
  logic                       STB;
  logic                       ACK;
  logic                       WE;
  logic                       ERR;

  modport master (output ADR, DAT_W, SEL, CYC, STB, ACK, WE, ERR);
  modport slave  (input  ADR, DAT_W, SEL, CYC, STB, ACK, WE, ERR);
endinterface

// File: rtl/wb_vmon_entry_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on rd_data whenever
// empty is low. Count and flags are registered; a push while full is ignored
// even if a pop happens in the same cycle.
module wb_vmon_entry_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [AW:0]      count_next;
  logic             full_reg;
  logic             empty_reg;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push & ~full_reg;
  assign pop_ok  = pop & ~empty_reg;

  // Occupancy after this cycle's accepted push/pop.
  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + (AW + 1)'(1);
      2'b01:   count_next = count_reg - (AW + 1)'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr_reg] <= wr_data;
  end

  // Pointers, count and flags.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      full_reg  <= (count_next == (AW + 1)'(DEPTH));
      empty_reg <= (count_next == '0);
    end
  end

  assign rd_data = mem[rd_ptr_reg];
  assign count   = count_reg;
  assign full    = full_reg;
  assign empty   = empty_reg;
endmodule

// File: rtl/wb_vmon_capture.sv
// Passive multi-channel Wishbone write monitor. Acked writes to NUM_CHANNELS
// consecutive words are packed into FIFO entries and sent out as frames of
// {chan,len-1} header followed by the selected bytes, LSB first.
module wb_vmon_capture
  import wb_vmon_capture_pkg::*;
#(
  parameter int                     WB_ADDR_WIDTH = 32,
  parameter int                     WB_DATA_WIDTH = 32,
  parameter logic [WB_ADDR_WIDTH-1:0] ADDRESS     = '0,
  parameter int                     NUM_CHANNELS  = 4,
  parameter int                     FIFO_DEPTH    = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  wb_vmon_capture_if.slave  wb,
  input  logic              en_i,
  input  logic              clr_i,
  output logic [7:0]        m_dat_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic              m_last_o,
  output logic [15:0]       drop_cnt_o,
  output logic              ovf_o,
  output logic              sel_err_o
);
  localparam int NB  = WB_DATA_WIDTH / 8;
  localparam int BSH = $clog2(NB);
  localparam int EW  = CHAN_W + LEN_W + WB_DATA_WIDTH;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  if (WB_DATA_WIDTH < 8 || WB_DATA_WIDTH > 128 ||
      (WB_DATA_WIDTH & (WB_DATA_WIDTH - 1)) != 0) begin : g_bad_width
    $fatal(1, "WB_DATA_WIDTH must be a power of 2 in 8..128");
  end
  if (NUM_CHANNELS < 1 || NUM_CHANNELS > 16) begin : g_bad_chan
    $fatal(1, "NUM_CHANNELS must be in 1..16");
  end
  if ((ADDRESS % WB_ADDR_WIDTH'(NB)) != '0) begin : g_bad_addr
    $fatal(1, "ADDRESS must be word aligned");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "FIFO_DEPTH must be a power of 2, >= 2");
  end

  // ---------------- hit decode and byte packing ----------------
  logic [WB_ADDR_WIDTH-1:0] chan_off;
  logic                     hit;
  sel_info_t                sinfo;
  logic [WB_DATA_WIDTH-1:0] shifted;
  logic [WB_DATA_WIDTH-1:0] packed_dat;
  logic [EW-1:0]            entry;

  // Unsigned word offset: addresses below ADDRESS wrap to huge values and miss.
  assign chan_off = (wb.ADR >> BSH) - (ADDRESS >> BSH);
  assign hit      = wb.CYC & wb.STB & wb.ACK & wb.WE & ~wb.ERR & en_i &
                    (chan_off < WB_ADDR_WIDTH'(NUM_CHANNELS));
  assign sinfo    = sel_contig(MAX_LANES'(wb.SEL));
  assign shifted  = wb.DAT_W >> {sinfo.lsb_lane, 3'b000};

  // Right-align the selected lanes and zero the unused upper bytes.
  for (genvar gi = 0; gi < NB; gi++) begin : g_pack
    assign packed_dat[gi*8 +: 8] = (5'(gi) < sinfo.nbytes) ? shifted[gi*8 +: 8] : 8'h00;
  end

  assign entry = {CHAN_W'(chan_off), LEN_W'(sinfo.nbytes - 5'd1), packed_dat};

  // ---------------- entry FIFO ----------------
  logic          fifo_push;
  logic          fifo_pop;
  logic [EW-1:0] head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          drop;
  logic          sel_bad;

  assign fifo_push = hit & sinfo.ok;
  assign drop      = hit & sinfo.ok & fifo_full;
  assign sel_bad   = hit & ~sinfo.ok;

  wb_vmon_entry_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push    (fifo_push),
    .wr_data (entry),
    .pop     (fifo_pop),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  logic [CHAN_W-1:0]        h_chan;
  logic [LEN_W-1:0]         h_len;
  logic [WB_DATA_WIDTH-1:0] h_data;

  assign h_chan = head[EW-1 -: CHAN_W];
  assign h_len  = head[WB_DATA_WIDTH +: LEN_W];
  assign h_data = head[WB_DATA_WIDTH-1:0];

  // ---------------- stream framer ----------------
  state_e           state_reg;
  state_e           state_next;
  logic [LEN_W-1:0] idx_reg;
  logic [LEN_W-1:0] idx_next;
  logic             hs;

  assign hs = m_valid_o & m_ready_i;

  // Framer state and byte index register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  // Next state: after the last byte, go straight to the next header if another
  // entry remains (or is arriving) so back-to-back frames have no bubble.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: if (!fifo_empty) state_next = HDR;
      HDR: begin
        if (hs) begin
          state_next = DATA;
          idx_next   = '0;
        end
      end
      DATA: begin
        if (hs) begin
          if (m_last_o) begin
            idx_next   = '0;
            state_next = (fifo_count > CW'(1) || fifo_push) ? HDR : IDLE;
          end else begin
            idx_next = idx_reg + LEN_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Stream outputs come from the held FIFO head, so they stay stable under stall.
  always_comb begin
    m_valid_o = 1'b0;
    m_dat_o   = 8'h00;
    m_last_o  = 1'b0;
    fifo_pop  = 1'b0;
    case (state_reg)
      HDR: begin
        m_valid_o = 1'b1;
        m_dat_o   = {h_chan, h_len};
      end
      DATA: begin
        m_valid_o = 1'b1;
        m_dat_o   = 8'(h_data >> {idx_reg, 3'b000});
        m_last_o  = (idx_reg == h_len);
        fifo_pop  = m_ready_i & (idx_reg == h_len);
      end
      default: ;
    endcase
  end

  // ---------------- status counters ----------------
  logic [15:0] drop_cnt_reg;
  logic        ovf_reg;
  logic        sel_err_reg;

  // Drop/overflow/select-error accounting; clear wins over same-cycle events.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clr_i) begin
      drop_cnt_reg <= '0;
      ovf_reg      <= 1'b0;
      sel_err_reg  <= 1'b0;
    end else begin
      if (drop) begin
        ovf_reg <= 1'b1;
        if (drop_cnt_reg != 16'hFFFF) drop_cnt_reg <= drop_cnt_reg + 16'd1;
      end
      if (sel_bad) sel_err_reg <= 1'b1;
    end
  end

  assign drop_cnt_o = drop_cnt_reg;
  assign ovf_o      = ovf_reg;
  assign sel_err_o  = sel_err_reg;
endmodule

// File: tb/tb_wb_vmon_capture.sv
// Directed bench for wb_vmon_capture: 32-bit bus, 4 channels at 'h100, 8-deep FIFO.
module tb_wb_vmon_capture;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        clr = 1'b0;
  logic [7:0]  m_dat;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_last;
  logic [15:0] drop_cnt;
  logic        ovf;
  logic        sel_err;

  int vectors = 0;
  int miscompares = 0;
  int cyc_cnt = 0;

  logic [8:0] exp_q[$];
  logic       prod_done = 1'b0;

  wb_vmon_capture_if #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32)) wb ();

  wb_vmon_capture #(
    .WB_ADDR_WIDTH (32),
    .WB_DATA_WIDTH (32),
    .ADDRESS       (32'h0000_0100),
    .NUM_CHANNELS  (4),
    .FIFO_DEPTH    (8)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .wb         (wb),
    .en_i       (en),
    .clr_i      (clr),
    .m_dat_o    (m_dat),
    .m_valid_o  (m_valid),
    .m_ready_i  (m_ready),
    .m_last_o   (m_last),
    .drop_cnt_o (drop_cnt),
    .ovf_o      (ovf),
    .sel_err_o  (sel_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One acked write cycle, driven at a falling edge; returns at the next falling edge.
  task automatic wb_write(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat,
                          input logic en_v = 1'b1, input logic err_v = 1'b0);
    wb.ADR = adr; wb.SEL = sel; wb.DAT_W = dat;
    wb.CYC = 1'b1; wb.STB = 1'b1; wb.ACK = 1'b1; wb.WE = 1'b1; wb.ERR = err_v; en = en_v;
    @(negedge clk);
    wb.CYC = 1'b0; wb.STB = 1'b0; wb.ACK = 1'b0; wb.WE = 1'b0; wb.ERR = 1'b0; en = 1'b1;
  endtask

  // Take one stream byte with m_ready already high; bounded wait for valid.
  task automatic get_byte(output logic [7:0] b, output logic l);
    int t;
    t = 0;
    while (!m_valid && t < 64) begin
      @(negedge clk);
      t++;
    end
    check("byte_wait", 32'(m_valid), 32'd1);
    b = m_dat;
    l = m_last;
    @(negedge clk);
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] hdr, input int n, input logic [31:0] dat);
    logic [7:0] b;
    logic       l;
    get_byte(b, l);
    check({tag, "_hdr"}, 32'(b), 32'(hdr));
    check({tag, "_hdr_last"}, 32'(l), 32'd0);
    for (int i = 0; i < n; i++) begin
      get_byte(b, l);
      check({tag, "_byte"}, 32'(b), 32'(dat[8*i +: 8]));
      check({tag, "_last"}, 32'(l), 32'(i == n - 1));
    end
  endtask

  initial begin
    logic [7:0] b;
    logic       l;
    int         t0;

    wb.ADR = '0; wb.DAT_W = '0; wb.SEL = '0;
    wb.CYC = 1'b0; wb.STB = 1'b0; wb.ACK = 1'b0; wb.WE = 1'b0; wb.ERR = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_dat", 32'(m_dat), 32'd0);
    check("rst_last", 32'(m_last), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_selerr", 32'(sel_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: full-word write to channel 2, with latency check
    m_ready = 1'b1;
    wb_write(32'h108, 4'b1111, 32'hDDCC_BBAA);
    check("t1_lat_n1", 32'(m_valid), 32'd0);
    @(negedge clk);
    check("t1_lat_n2", 32'(m_valid), 32'd1);
    expect_frame("t1", 8'h23, 4, 32'hDDCC_BBAA);
    @(negedge clk);
    check("t1_idle", 32'(m_valid), 32'd0);

    // 2: partial select, then an illegal select and clear
    wb_write(32'h100, 4'b0110, 32'h00BE_EF00);
    expect_frame("t2", 8'h01, 2, 32'h0000_BEEF);
    check("t2_selerr_pre", 32'(sel_err), 32'd0);
    wb_write(32'h104, 4'b0101, 32'h1234_5678);
    check("t2_selerr", 32'(sel_err), 32'd1);
    repeat (3) @(negedge clk);
    check("t2_noframe", 32'(m_valid), 32'd0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("t2_clr", 32'(sel_err), 32'd0);

    // 3: overflow with the sink stalled, then in-order drain at full rate
    m_ready = 1'b0;
    for (int k = 0; k < 9; k++)
      wb_write(32'h100 + 32'(4 * (k % 4)), 4'b1111, 32'h0302_0100 + 32'h1010_1010 * 32'(k));
    check("t3_drop", 32'(drop_cnt), 32'd1);
    check("t3_ovf", 32'(ovf), 32'd1);
    repeat (2) @(negedge clk);
    check("t3_stall_valid", 32'(m_valid), 32'd1);
    check("t3_stall_dat", 32'(m_dat), 32'h03);
    m_ready = 1'b1;
    t0 = cyc_cnt;
    for (int k = 0; k < 8; k++)
      expect_frame("t3", 8'((k % 4) * 16 + 3), 4, 32'h0302_0100 + 32'h1010_1010 * 32'(k));
    check("t3_rate", 32'(cyc_cnt - t0), 32'd40);
    @(negedge clk);
    check("t3_empty", 32'(m_valid), 32'd0);

    // 4: random legal writes against a random-ready sink, scoreboarded
    fork
      begin : producer
        for (int w = 0; w < 40; w++) begin
          int          c, lsb, n;
          logic [31:0] d;
          logic [3:0]  sel;
          c   = $urandom_range(0, 3);
          lsb = $urandom_range(0, 3);
          n   = $urandom_range(1, 4 - lsb);
          d   = $urandom;
          sel = 4'(((1 << n) - 1) << lsb);
          exp_q.push_back({1'b0, 4'(c), 4'(n - 1)});
          for (int i = 0; i < n; i++)
            exp_q.push_back({1'(i == n - 1), d[8*(lsb+i) +: 8]});
          wb_write(32'h100 + 32'(4 * c), sel, d);
          repeat ($urandom_range(10, 16)) @(negedge clk);
        end
        prod_done = 1'b1;
      end
      begin : consumer
        logic       pv, pr, pl;
        logic [7:0] pd;
        logic [8:0] e;
        int         cyc;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; cyc = 0;
        while (!(prod_done && exp_q.size() == 0) && cyc < 20000) begin
          @(negedge clk);
          cyc++;
          if (pv && !pr) begin
            check("t4_hold_valid", 32'(m_valid), 32'd1);
            check("t4_hold_dat", 32'(m_dat), 32'(pd));
            check("t4_hold_last", 32'(m_last), 32'(pl));
          end
          m_ready = 1'($urandom_range(0, 1));
          if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
              check("t4_extra", 32'(m_valid), 32'd0);
            end else begin
              e = exp_q.pop_front();
              check("t4_dat", 32'(m_dat), 32'(e[7:0]));
              check("t4_last", 32'(m_last), 32'(e[8]));
            end
          end
          pv = m_valid; pr = m_ready; pd = m_dat; pl = m_last;
        end
        check("t4_drained", 32'(exp_q.size()), 32'd0);
      end
    join
    @(negedge clk);
    m_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("t4_idle", 32'(m_valid), 32'd0);
    check("t4_drop", 32'(drop_cnt), 32'd1);
    check("t4_selerr", 32'(sel_err), 32'd0);

    // 5: reset in the middle of a data phase; a hit during reset is ignored
    wb_write(32'h104, 4'b1111, 32'h4433_2211);
    wb_write(32'h108, 4'b1111, 32'h8877_6655);
    m_ready = 1'b1;
    get_byte(b, l);
    check("t5_hdr", 32'(b), 32'h13);
    get_byte(b, l);
    check("t5_b0", 32'(b), 32'h11);
    check("t5_mid_valid", 32'(m_valid), 32'd1);
    check("t5_pre_drop", 32'(drop_cnt), 32'd1);
    rst_n = 1'b0;
    wb_write(32'h100, 4'b1111, 32'hCAFE_F00D);
    check("t5_valid", 32'(m_valid), 32'd0);
    check("t5_dat", 32'(m_dat), 32'd0);
    check("t5_last", 32'(m_last), 32'd0);
    check("t5_drop", 32'(drop_cnt), 32'd0);
    check("t5_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_fifo_empty", 32'(m_valid), 32'd0);
    end

    // 6: misses (past last channel, below base, disabled, error cycle)
    wb_write(32'h110, 4'b1111, 32'h1111_1111);
    wb_write(32'h0FC, 4'b1111, 32'h2222_2222);
    wb_write(32'h100, 4'b1111, 32'h3333_3333, 1'b0, 1'b0);
    wb_write(32'h100, 4'b1111, 32'h4444_4444, 1'b1, 1'b1);
    wb_write(32'h100, 4'b0101, 32'h5555_5555, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_noframe", 32'(m_valid), 32'd0);
    end
    check("t6_drop", 32'(drop_cnt), 32'd0);
    check("t6_ovf", 32'(ovf), 32'd0);
    check("t6_selerr", 32'(sel_err), 32'd0);
    wb_write(32'h10C, 4'b1000, 32'h5A00_0000);
    expect_frame("t6", 8'h30, 1, 32'h0000_005A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
